// File: rtl/spi_frame_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_master_if
// Description : Bundles the start/done handshake, frame data and SPI pins
//               of spi_frame_master.
//               master modport : the SPI master block (drives SCK/MOSI/SSEL,
//                                busy/done/rx_frame; reads start/tx_frame/MISO)
//               slave modport  : the controller plus SPI slave side (mirror)
// Revision    : 1.0  initial release
// ============================================================================
interface spi_frame_master_if #(
  parameter int unsigned FRAME_BITS = 88
);
  logic                  start;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx_frame;
  logic                  SCK;
  logic                  MOSI;
  logic                  MISO;
  logic                  SSEL;

  modport master (
    input  start, tx_frame, MISO,
    output busy, done, rx_frame, SCK, MOSI, SSEL
  );

  modport slave (
    output start, tx_frame, MISO,
    input  busy, done, rx_frame, SCK, MOSI, SSEL
  );
endinterface
`default_nettype wire

// File: rtl/spi_frame_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_master
// Description : Mode-0 SPI master. Sends one FRAME_BITS-long frame MSB first
//               and captures the frame returned on MISO.
//               clk50M : system clock (rising edge)
//               rst    : synchronous active-high reset
//               bus    : spi_frame_master_if.master (start/tx_frame in,
//                        busy/done/rx_frame out, SCK/MOSI/SSEL out, MISO in)
// Revision    : 1.0  initial release
// ============================================================================
module spi_frame_master #(
  parameter int unsigned FRAME_BITS = 88,
  parameter int unsigned CLK_DIV    = 25
) (
  input  wire logic               clk50M,
  input  wire logic               rst,
  spi_frame_master_if.master      bus
);

  localparam int unsigned          C_CNT_W    = $clog2(CLK_DIV);
  localparam int unsigned          C_BIT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(CLK_DIV - 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_ONE  = C_CNT_W'(1);
  localparam logic [C_BIT_W-1:0]   C_BIT_LAST = C_BIT_W'(FRAME_BITS - 1);
  localparam logic [C_BIT_W-1:0]   C_BIT_ONE  = C_BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_HOLD = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t                state_q,  state_d;
  logic [C_CNT_W-1:0]    cnt_q,    cnt_d;
  logic [C_BIT_W-1:0]    bit_q,    bit_d;
  logic [FRAME_BITS-1:0] tx_q,     tx_d;
  logic [FRAME_BITS-1:0] rx_q,     rx_d;
  logic [FRAME_BITS-1:0] rxf_q,    rxf_d;
  logic                  sck_q,    sck_d;
  logic                  mosi_q,   mosi_d;
  logic                  ssel_q,   ssel_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  wire logic w_phase_end = (cnt_q == C_CNT_LAST);

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxf_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ssel_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxf_q   <= rxf_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ssel_q  <= ssel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxf_d   = rxf_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ssel_d  = ssel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // MSB goes straight to MOSI; the shift register keeps the rest
          // left-aligned so the next bit is always at the top.
          tx_d    = {bus.tx_frame[FRAME_BITS-2:0], 1'b0};
          rx_d    = '0;
          mosi_d  = bus.tx_frame[FRAME_BITS-1];
          ssel_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_LOW;
        end
      end

      S_LOW: begin
        if (w_phase_end) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_HIGH: begin
        if (w_phase_end) begin
          cnt_d = '0;
          sck_d = 1'b0;
          // Sample on the same edge that drops SCK: the slave's mode-0
          // output is still the value it presented for this bit.
          rx_d  = {rx_q[FRAME_BITS-2:0], bus.MISO};
          bit_d = bit_q + C_BIT_ONE;
          if (bit_q == C_BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            mosi_d  = tx_q[FRAME_BITS-1];
            tx_d    = {tx_q[FRAME_BITS-2:0], 1'b0};
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_HOLD: begin
        if (w_phase_end) begin
          cnt_d   = '0;
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_GAP: begin
        if (w_phase_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          done_d  = 1'b1;
          rxf_d   = rx_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.SCK      = sck_q;
  assign bus.MOSI     = mosi_q;
  assign bus.SSEL     = ssel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_frame = rxf_q;

endmodule
`default_nettype wire

// File: doc/spi_frame_master.md
# spi_frame_master

Full-duplex SPI master that sends one fixed-length command frame and captures the frame shifted back on MISO. It is the initiator for the board's 88-bit SPI slave: it carries set-points (PWM duties, blind position, modes) in one direction and carries humidity/status bytes back. It sits in the clk50M domain and is driven by a bench or test controller through a start/done handshake.

## Interface
- FRAME_BITS, 88, bits per frame (>=2); MSB first.
- CLK_DIV, 25, clk50M cycles per SCK half-period (>=2); the default gives a 1 MHz SCK.
- clk50M  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a frame; sampled only while busy=0.
- tx_frame  input  FRAME_BITS  frame to send; captured on the accepted start cycle.
- busy  output  1  high from the cycle after an accepted start until the done cycle.
- done  output  1  one-cycle pulse; rx_frame is valid from this cycle.
- rx_frame  output  FRAME_BITS  last complete received frame; bit FRAME_BITS-1 is the first bit received.
- SCK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- MOSI  output  1  master data out.
- MISO  input  1  slave data in.
- SSEL  output  1  slave select, active low.

## Operation
- Reset values: SSEL=1, SCK=0, MOSI=0, busy=0, done=0, rx_frame=0. The state is IDLE and all counters are 0.
- Cycle 0 is the cycle in which the block is in IDLE with start=1. In that cycle it loads tx_frame into the TX shift register and clears the RX shift register.
- On the next clock edge it sets SSEL=0, MOSI=tx_frame[MSB] and busy=1, then moves to LOW.
- LOW state:
  - SCK=0 for CLK_DIV cycles.
  - It then sets SCK=1 and moves to HIGH.
- HIGH state:
  - SCK=1 for CLK_DIV cycles.
  - On the edge that ends HIGH, it sets SCK=0 and shifts MISO into RX bit 0 (MISO is registered directly, with no synchronizer).
  - If bits remain, it drives the next TX bit on MOSI and returns to LOW.
  - After bit FRAME_BITS it moves to HOLD with MOSI unchanged.
- HOLD state: SSEL stays low for CLK_DIV cycles. It then sets SSEL=1 and MOSI=0 and moves to GAP.
- GAP state: SSEL stays high for CLK_DIV cycles. It then pulses done=1, copies the RX shift register to rx_frame, sets busy=0 and returns to IDLE.
- start:
  - start while busy=1 is ignored; it is not queued.
  - start=1 in the done cycle is accepted, so back-to-back frames are possible.
- Every frame is exactly FRAME_BITS bits; there are no partial frames.
- Counters:
  - The half-period counter is $clog2(CLK_DIV) bits wide and counts 0..CLK_DIV-1.
  - The bit counter is $clog2(FRAME_BITS+1) bits wide.
  - Neither counter may wrap inside a phase.
- Reset mid-frame:
  - All outputs return to their reset values on the next edge.
  - SSEL rises immediately, which aborts the slave transaction.
  - No done pulse is produced for the aborted frame, and rx_frame reads 0.
- rx_frame changes only in the done cycle. It holds its value while the next frame is in progress.

## Timing
- E0 is the clock edge ending cycle 0; at E0 SSEL falls and MOSI presents bit 0.
- Bit i (counting from 0):
  - SCK rises at E0+(2i+1)·CLK_DIV.
  - SCK falls and MISO is sampled at E0+(2i+2)·CLK_DIV.
- MOSI changes only on SCK falling edges (or at E0). It is therefore stable for CLK_DIV cycles before every SCK rise.
- SSEL rises at E0+(2·FRAME_BITS+1)·CLK_DIV.
- done and busy=0 are registered at E0+(2·FRAME_BITS+2)·CLK_DIV.
  - With the defaults this is 178·25 = 4450 cycles after E0.
- SSEL is high for at least CLK_DIV cycles between frames.
- SCK is low whenever SSEL is high.

## Test plan
- Single frame with CLK_DIV=2, FRAME_BITS=8, tx_frame=8'hA5 and MISO tied to MOSI:
  - MOSI bit sequence 1,0,1,0,0,1,0,1.
  - rx_frame=8'hA5.
  - done exactly 36 cycles after E0 (for 8 bits: (2·8+2)·2 = 36).
  - Exactly 8 SCK rising edges.
- Default parameters with a mode-0 slave model returning 88'h0123_4567_89AB_CDEF_0011_22 while the master sends 88'hFFEE_DDCC_BBAA_9988_7766_55:
  - The slave captures the sent value.
  - rx_frame equals the slave's value.
  - SCK high and low phases each 25 cycles.
- start held high throughout a frame:
  - Exactly one frame runs.
  - The next frame is accepted in the done cycle, and the second SSEL falls one cycle after done.
  - SSEL stays high for at least CLK_DIV cycles between the frames.
- rst asserted after the 3rd SCK rise:
  - Next cycle: SSEL=1, SCK=0, MOSI=0, busy=0.
  - No done pulse; rx_frame=0.
  - A subsequent start completes normally.
- Continuous checker across all tests:
  - MOSI never toggles while SCK=1.
  - SCK never toggles while SSEL=1.
  - done is never asserted for more than one cycle.
  - busy never overlaps IDLE.
